// File: rtl/arc4_key_search.sv
// Key-range search controller for a single arc4 core: launches one decryption
// per key, snoops the plaintext writes and stops on the first all-printable message.
module arc4_key_search #(
  parameter logic [23:0] KEY_START = 24'h000000,
  parameter logic [23:0] KEY_STEP  = 24'h000001
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  output logic        rdy,
  input  logic        stop,
  output logic [23:0] key,
  output logic        key_valid,
  output logic        a4_en,
  input  logic        a4_rdy,
  output logic [23:0] a4_key,
  input  logic [7:0]  a4_pt_addr,
  input  logic [7:0]  a4_pt_wrdata,
  input  logic        a4_pt_wren
);

  typedef enum logic [2:0] {IDLE, LAUNCH, ACK, RUN, DECIDE} state_t;

  state_t      state_reg;
  logic        bad_reg;
  logic        stop_reg;
  logic        snooping;
  logic        byte_bad;
  logic        stop_hit;
  logic [24:0] sum_next;

  assign snooping = (state_reg == LAUNCH) || (state_reg == ACK) || (state_reg == RUN);
  // Address 0 carries the message length, not text, so it is never judged.
  assign byte_bad = a4_pt_wren && (a4_pt_addr != 8'h00) &&
                    ((a4_pt_wrdata < 8'h20) || (a4_pt_wrdata > 8'h7E));
  assign stop_hit = stop_reg || stop;
  assign sum_next = {1'b0, a4_key} + {1'b0, KEY_STEP};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      rdy       <= 1'b1;
      key_valid <= 1'b0;
      key       <= 24'h000000;
      a4_en     <= 1'b0;
      a4_key    <= KEY_START;
      bad_reg   <= 1'b0;
      stop_reg  <= 1'b0;
    end else begin
      if (state_reg != IDLE && stop)
        stop_reg <= 1'b1;
      if (snooping && byte_bad)
        bad_reg <= 1'b1;

      case (state_reg)
        IDLE: begin
          if (en) begin
            a4_key    <= KEY_START;
            key_valid <= 1'b0;
            stop_reg  <= 1'b0;
            bad_reg   <= 1'b0;
            rdy       <= 1'b0;
            a4_en     <= 1'b1;
            state_reg <= LAUNCH;
          end
        end
        LAUNCH: begin
          if (a4_rdy) begin
            a4_en     <= 1'b0;
            state_reg <= ACK;
          end
        end
        ACK: begin
          if (!a4_rdy)
            state_reg <= RUN;
        end
        RUN: begin
          if (a4_rdy)
            state_reg <= DECIDE;
        end
        DECIDE: begin
          // A printable result wins over a pending cancel; the carry ends the range.
          if (!bad_reg) begin
            key       <= a4_key;
            key_valid <= 1'b1;
            rdy       <= 1'b1;
            state_reg <= IDLE;
          end else if (stop_hit || sum_next[24]) begin
            key       <= a4_key;
            key_valid <= 1'b0;
            rdy       <= 1'b1;
            state_reg <= IDLE;
          end else begin
            a4_key    <= sum_next[23:0];
            a4_en     <= 1'b1;
            bad_reg   <= 1'b0;
            state_reg <= LAUNCH;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_arc4_key_search.sv
// Directed bench for arc4_key_search with a behavioural arc4 that writes a
// per-key byte pattern; two controllers share the model, one active at a time.
module tb_arc4_key_search;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en_0 = 1'b0, en_x = 1'b0;
  logic        stop = 1'b0;
  logic        sel = 1'b0;

  logic        rdy_0, kv_0, a4_en_0;
  logic [23:0] key_0, a4_key_0;
  logic        rdy_x, kv_x, a4_en_x;
  logic [23:0] key_x, a4_key_x;

  logic        m_rdy;
  logic [7:0]  m_addr, m_data;
  logic        m_wren;
  logic [23:0] m_key;
  logic [3:0]  m_cnt;

  logic [7:0]  good_pat [0:5];
  logic [7:0]  bad_pat  [0:5];
  logic        hit_en = 1'b0;
  logic [23:0] hit_key = 24'h0;
  logic [23:0] launch_log [$];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  arc4_key_search dut_0 (
    .clk(clk), .rst_n(rst_n), .en(en_0), .rdy(rdy_0), .stop(stop),
    .key(key_0), .key_valid(kv_0), .a4_en(a4_en_0), .a4_rdy(m_rdy),
    .a4_key(a4_key_0), .a4_pt_addr(m_addr), .a4_pt_wrdata(m_data), .a4_pt_wren(m_wren)
  );

  arc4_key_search #(.KEY_START(24'hFFFFFD), .KEY_STEP(24'h000002)) dut_x (
    .clk(clk), .rst_n(rst_n), .en(en_x), .rdy(rdy_x), .stop(stop),
    .key(key_x), .key_valid(kv_x), .a4_en(a4_en_x), .a4_rdy(m_rdy),
    .a4_key(a4_key_x), .a4_pt_addr(m_addr), .a4_pt_wrdata(m_data), .a4_pt_wren(m_wren)
  );

  wire        s_rdy    = sel ? rdy_x    : rdy_0;
  wire        s_kv     = sel ? kv_x     : kv_0;
  wire        s_a4_en  = sel ? a4_en_x  : a4_en_0;
  wire [23:0] s_key    = sel ? key_x    : key_0;
  wire [23:0] s_a4_key = sel ? a4_key_x : a4_key_0;

  // Behavioural arc4: accept, drop rdy, write addr 0..5, raise rdy.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_rdy <= 1'b1; m_cnt <= 4'd0; m_wren <= 1'b0;
      m_addr <= 8'h00; m_data <= 8'h00; m_key <= 24'h0;
    end else if (m_rdy && s_a4_en) begin
      m_rdy <= 1'b0; m_key <= s_a4_key; m_cnt <= 4'd0; m_wren <= 1'b0;
      launch_log.push_back(s_a4_key);
    end else if (!m_rdy) begin
      if (m_cnt <= 4'd5) begin
        m_wren <= 1'b1;
        m_addr <= {4'h0, m_cnt};
        m_data <= (hit_en && m_key == hit_key) ? good_pat[m_cnt[2:0]] : bad_pat[m_cnt[2:0]];
        m_cnt  <= m_cnt + 4'd1;
      end else begin
        m_wren <= 1'b0;
        m_rdy  <= 1'b1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic start(input logic [23:0] exp_key);
    @(negedge clk);
    launch_log.delete();
    if (sel) en_x = 1'b1; else en_0 = 1'b1;
    @(posedge clk); #1;
    en_0 = 1'b0; en_x = 1'b0;
    check("acc_rdy", {31'd0, s_rdy}, 32'd0);
    check("acc_a4_en", {31'd0, s_a4_en}, 32'd1);
    check("acc_a4_key", {8'd0, s_a4_key}, {8'd0, exp_key});
  endtask

  task automatic wait_rdy();
    int n = 0;
    while (!s_rdy && n < 3000) begin
      @(negedge clk); n++;
    end
    check("done_rdy", {31'd0, s_rdy}, 32'd1);
  endtask

  task automatic wait_launches(input int cnt);
    int n = 0;
    while (launch_log.size() < cnt && n < 3000) begin
      @(negedge clk); n++;
    end
    check("launch_cnt_reached", launch_log.size(), cnt);
  endtask

  task automatic pulse_stop_in_run();
    @(negedge clk);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
  endtask

  task automatic set_good_default();
    good_pat[0] = 8'h05; good_pat[1] = 8'h20; good_pat[2] = 8'h7E;
    good_pat[3] = 8'h20; good_pat[4] = 8'h7E; good_pat[5] = 8'h20;
  endtask

  initial begin
    set_good_default();
    bad_pat[0] = 8'h05; bad_pat[1] = 8'h41; bad_pat[2] = 8'h42;
    bad_pat[3] = 8'h43; bad_pat[4] = 8'h44; bad_pat[5] = 8'h1F;
    repeat (3) @(negedge clk);
    check("rst_rdy", {31'd0, rdy_0}, 32'd1);
    check("rst_kv", {31'd0, kv_0}, 32'd0);
    check("rst_a4_en", {31'd0, a4_en_0}, 32'd0);
    check("rst_a4_key_x", {8'd0, a4_key_x}, 32'hFFFFFD);
    rst_n = 1'b1;

    // Hit on key 3
    hit_en = 1'b1; hit_key = 24'd3;
    start(24'd0);
    wait_rdy();
    check("hit3_nlaunch", launch_log.size(), 4);
    for (int i = 0; i < 4 && i < launch_log.size(); i++)
      check($sformatf("hit3_key%0d", i), {8'd0, launch_log[i]}, i);
    check("hit3_kv", {31'd0, s_kv}, 32'd1);
    check("hit3_key", {8'd0, s_key}, 32'd3);

    // Length byte 05 ignored, 20/7E accepted
    hit_key = 24'd0;
    start(24'd0);
    wait_rdy();
    check("edge_nlaunch", launch_log.size(), 1);
    check("edge_kv", {31'd0, s_kv}, 32'd1);
    check("edge_key", {8'd0, s_key}, 32'd0);

    // 7F at addr 2 rejects key 0; stop ends the search there
    good_pat[2] = 8'h7F;
    start(24'd0);
    wait_launches(1);
    pulse_stop_in_run();
    wait_rdy();
    check("7f_nlaunch", launch_log.size(), 1);
    check("7f_kv", {31'd0, s_kv}, 32'd0);
    check("7f_key", {8'd0, s_key}, 32'd0);
    set_good_default();

    // Exhaustion on the high-start controller
    sel = 1'b1; hit_en = 1'b0;
    start(24'hFFFFFD);
    wait_rdy();
    check("exh_nlaunch", launch_log.size(), 2);
    if (launch_log.size() >= 2) begin
      check("exh_key0", {8'd0, launch_log[0]}, 32'hFFFFFD);
      check("exh_key1", {8'd0, launch_log[1]}, 32'hFFFFFF);
    end
    check("exh_kv", {31'd0, s_kv}, 32'd0);
    check("exh_key", {8'd0, s_key}, 32'hFFFFFF);
    sel = 1'b0;

    // Stop during the run of key 5
    start(24'd0);
    wait_launches(6);
    pulse_stop_in_run();
    wait_rdy();
    check("stop_nlaunch", launch_log.size(), 6);
    check("stop_kv", {31'd0, s_kv}, 32'd0);
    check("stop_key", {8'd0, s_key}, 32'd5);

    // Printable result beats a concurrent stop
    hit_en = 1'b1; hit_key = 24'd2;
    start(24'd0);
    wait_launches(3);
    pulse_stop_in_run();
    wait_rdy();
    check("hbs_nlaunch", launch_log.size(), 3);
    check("hbs_kv", {31'd0, s_kv}, 32'd1);
    check("hbs_key", {8'd0, s_key}, 32'd2);

    // Asynchronous reset while in ACK of key 1
    hit_en = 1'b0;
    start(24'd0);
    wait_launches(2);
    #1 rst_n = 1'b0;
    #1;
    check("mrst_rdy", {31'd0, rdy_0}, 32'd1);
    check("mrst_a4_en", {31'd0, a4_en_0}, 32'd0);
    check("mrst_kv", {31'd0, kv_0}, 32'd0);
    check("mrst_key", {8'd0, key_0}, 32'd0);
    check("mrst_a4_key", {8'd0, a4_key_0}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Restart from KEY_START after reset
    hit_en = 1'b1; hit_key = 24'd1;
    start(24'd0);
    wait_rdy();
    check("rest_nlaunch", launch_log.size(), 2);
    if (launch_log.size() >= 1)
      check("rest_first", {8'd0, launch_log[0]}, 32'd0);
    check("rest_kv", {31'd0, s_kv}, 32'd1);
    check("rest_key", {8'd0, s_key}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
